mult_div_ctrl: RTL and testbench
================================

Name: mult_div_ctrl

Overview:
Sequencer for the signed MULT/DIV datapath in the multicycle MIPS core.
- Accepts a start pulse from the main control FSM and runs an iterative 32-step shift-add multiply or restoring divide on operand magnitudes.
- Applies sign correction and loads the 64-bit result into the HI/LO registers.
- Control stalls on busy and resumes on the one-cycle done pulse.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
start  input  1  request pulse; sampled only in IDLE.
op  input  1  0 = MULT, 1 = DIV.
a  input  WIDTH  rs operand, two's complement; the dividend for DIV.
b  input  WIDTH  rt operand, two's complement; the divisor for DIV.
busy  output  1  high while an operation is in progress, including DONE.
done  output  1  one-cycle pulse; HI/LO are valid in that cycle.
div_zero  output  1  sticky until next accepted start; DIV with b = 0.
hi_out  output  WIDTH  HI register: MULT upper product, DIV remainder.
lo_out  output  WIDTH  LO register: MULT lower product, DIV quotient.

Behaviour:
- Reset (reset = 0 at edge): state IDLE; busy = 0, done = 0, div_zero = 0, hi_out = 0, lo_out = 0; internal accumulators and counter cleared. Applies from any state; an aborted operation never writes HI/LO.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: start = 1 at edge E0 latches a, b, op, sign flags, and |a|, |b|. Counter = WIDTH. div_zero is cleared.
  - op = 1 with b = 0: go to DONE with div_zero = 1; HI/LO keep their old values.
  - Otherwise go to MUL (op = 0) or DIV (op = 1).
- start outside IDLE is ignored; no queuing.
- MUL, one step per cycle: if multiplier LSB = 1, add the multiplicand to the upper half of a 2×WIDTH accumulator (with carry), then shift right 1; counter decrements. After WIDTH steps, go to FIX.
- DIV, restoring, one step per cycle: shift {rem, quo} left 1, trial subtract |b| from rem. If non-negative, keep the result and set the quotient LSB to 1; else restore. After WIDTH steps, go to FIX.
- FIX, 1 cycle:
  - MULT: negate the 64-bit product if sign(a) ^ sign(b).
  - DIV: negate the quotient if sign(a) ^ sign(b); negate the remainder if sign(a). Remainder takes the dividend's sign, quotient truncates toward zero.
  - hi_out/lo_out are loaded at the end of FIX.
- DONE, 1 cycle: done = 1, busy = 1, then return to IDLE.
- Latency: start at edge E0 gives busy high from E0+1 and done high in cycle E0+WIDTH+2 (34 for WIDTH = 32). Div-by-zero gives done in cycle E0+1.
- Width rules:
  - Magnitudes are taken as unsigned WIDTH-bit values, so |0x80000000| = 0x80000000.
  - The accumulator is 2×WIDTH+1 bits during add.
  - DIV 0x80000000 / -1 yields LO = 0x80000000, HI = 0 (wraps, no trap).
- hi_out/lo_out change only at the end of FIX or on reset. They are stable in all other cycles, so readers may sample them at any time outside MUL/DIV/FIX.

Test Plan:
1. MULT a = 7, b = -3 (0xFFFFFFFD) → done 34 cycles after start; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; busy high for cycles 1–34.
2. MULT a = b = 0x80000000 → HI = 0x40000000, LO = 0x00000000; then a = 0xFFFFFFFF, b = 0xFFFFFFFF → HI = 0, LO = 1.
3. DIV a = -7, b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV a = 0x80000000, b = -1 → LO = 0x80000000, HI = 0.
4. DIV a = 5, b = 0 with prior HI/LO = 0x11/0x22 → done in cycle 1, div_zero = 1, HI/LO unchanged. The next valid start clears div_zero.
5. Start pulsed again in cycle 10 of a MULT → ignored; result and done timing identical to the single-start run; exactly one done pulse.
6. reset = 0 in cycle 20 of a DIV → next cycle: IDLE, busy = 0, done = 0, hi_out = lo_out = 0. No done pulse follows; a fresh start then completes normally.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// Iterative signed MULT/DIV sequencer: a 32-step shift-add multiply or restoring divide on
// operand magnitudes, followed by one sign-fix cycle that loads the HI/LO registers.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg, count_next;
    // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    // MUL: |a| (multiplicand); DIV: |b| (divisor)
    logic [WIDTH-1:0]   mag_reg, mag_next;
    logic               op_reg, op_next;
    logic               sign_a_reg, sign_a_next;
    logic               sign_b_reg, sign_b_next;
    logic               div_zero_reg, div_zero_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_top;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_acc;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Unsigned magnitudes: the most negative value maps onto itself, which is still correct
    // when read as an unsigned WIDTH-bit number.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // Multiply step: conditional add into the upper half with carry, then shift right.
    assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_reg[0] ? mag_reg : {WIDTH{1'b0}})};
    assign mul_acc = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide step: the remainder is always below the divisor, so after the
    // left shift it fits in WIDTH bits and the extra top bit of the trial acts as borrow.
    assign div_top   = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_top - {1'b0, mag_reg};
    assign div_acc   = div_trial[WIDTH]
                     ? {div_top[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

    // Sign correction: quotient truncates toward zero, remainder follows the dividend.
    assign prod_neg = -acc_reg;
    assign quo_fix  = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        acc_next      = acc_reg;
        mag_next      = mag_reg;
        op_next       = op_reg;
        sign_a_next   = sign_a_reg;
        sign_b_next   = sign_b_reg;
        div_zero_next = div_zero_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        busy          = 1'b1;
        done          = 1'b0;

        unique case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    op_next       = op;
                    sign_a_next   = a[WIDTH-1];
                    sign_b_next   = b[WIDTH-1];
                    count_next    = COUNT_INIT;
                    div_zero_next = 1'b0;
                    mag_next      = op ? abs_b : abs_a;
                    acc_next      = {{WIDTH{1'b0}}, (op ? abs_a : abs_b)};
                    if (op && (b == '0)) begin
                        // Divide by zero skips straight to DONE and leaves HI/LO untouched.
                        div_zero_next = 1'b1;
                        state_next    = DONE;
                    end else begin
                        state_next = op ? DIV : MUL;
                    end
                end
            end
            MUL: begin
                acc_next   = mul_acc;
                count_next = count_reg - COUNT_ONE;
                if (count_reg == COUNT_ONE) begin
                    state_next = FIX;
                end
            end
            DIV: begin
                acc_next   = div_acc;
                count_next = count_reg - COUNT_ONE;
                if (count_reg == COUNT_ONE) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                if (op_reg) begin
                    hi_next = rem_fix;
                    lo_next = quo_fix;
                end else if (sign_a_reg ^ sign_b_reg) begin
                    hi_next = prod_neg[2*WIDTH-1:WIDTH];
                    lo_next = prod_neg[WIDTH-1:0];
                end else begin
                    hi_next = acc_reg[2*WIDTH-1:WIDTH];
                    lo_next = acc_reg[WIDTH-1:0];
                end
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            acc_reg      <= '0;
            mag_reg      <= '0;
            op_reg       <= 1'b0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            acc_reg      <= acc_next;
            mag_reg      <= mag_next;
            op_reg       <= op_next;
            sign_a_reg   <= sign_a_next;
            sign_b_reg   <= sign_b_next;
            div_zero_reg <= div_zero_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
        end
    end

    assign div_zero = div_zero_reg;
    assign hi_out   = hi_reg;
    assign lo_out   = lo_reg;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: a signed arithmetic reference predicts HI/LO, div_zero
// and done latency at each start; results are popped and compared when done fires.
module tb_mult_div_ctrl;

    localparam int W = 32;
    localparam int TIMEOUT = 60;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    mult_div_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] old_hi, input logic [W-1:0] old_lo);
        exp_t   e;
        longint sx;
        longint sy;
        longint p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p = sx * sy;
            e.hi = p[63:32]; e.lo = p[31:0]; e.dz = 1'b0; e.lat = W + 2;
        end else if (y == '0) begin
            e.hi = old_hi; e.lo = old_lo; e.dz = 1'b1; e.lat = 1;
        end else begin
            p = sx / sy;
            e.lo = p[31:0];
            p = sx % sy;
            e.hi = p[31:0]; e.dz = 1'b0; e.lat = W + 2;
        end
        return e;
    endfunction

    // Drive one start pulse across edge E0 and record the prediction.
    task automatic start_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        e = model(o, x, y, model_hi, model_lo);
        sb_q.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after E0 until done; optionally re-pulses start with junk operands.
    task automatic wait_done(input int pulse_at, output int cyc, output bit busy_ok,
                             output bit stable_ok, output int done_cnt);
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        h0 = hi_out; l0 = lo_out;
        cyc = -1; busy_ok = 1'b1; stable_ok = 1'b1; done_cnt = 0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            if (c == pulse_at) begin
                start = 1'b1; op = 1'b1; a = 32'h0000_1234; b = 32'h0000_0000;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                done_cnt++;
                cyc = c;
                break;
            end
            if (hi_out !== h0 || lo_out !== l0) stable_ok = 1'b0;
        end
        start = 1'b0;
        // One more cycle: no second done pulse and back to idle.
        @(negedge clk);
        if (done) done_cnt++;
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/div_zero = %b, expected 000", {busy, done, div_zero});
        end
        n_checks++;
        if (hi_out !== '0 || lo_out !== '0) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h, expected 0/0", hi_out, lo_out);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [W-1:0] ta[5] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000};
        logic [W-1:0] tb[5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'hDEAD_BEEF};
        exp_t e;
        int cyc, dn;
        bit bok, sok;
        for (int i = 0; i < 5; i++) begin
            start_op(1'b0, ta[i], tb[i]);
            wait_done(0, cyc, bok, sok, dn);
            e = sb_q.pop_front();
            n_checks++;
            if (cyc !== e.lat || dn != 1) begin
                n_fail++;
                $display("FAIL mult_latency[%0d]: done at cycle %0d (%0d pulses), expected cycle %0d once", i, cyc, dn, e.lat);
            end
            n_checks++;
            if (hi_out !== e.hi || lo_out !== e.lo) begin
                n_fail++;
                $display("FAIL mult_result[%0d]: hi=%h lo=%h, expected hi=%h lo=%h", i, hi_out, lo_out, e.hi, e.lo);
            end
            n_checks++;
            if (!bok || !sok || div_zero !== e.dz) begin
                n_fail++;
                $display("FAIL mult_busy_stable[%0d]: busy_ok=%0b stable_ok=%0b div_zero=%b, expected 1/1/%b", i, bok, sok, div_zero, e.dz);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] ta[5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0064, 32'hFFFF_FF9C, 32'h0000_0007};
        logic [W-1:0] tb[5] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFF9, 32'hFFFF_FF9C};
        exp_t e;
        int cyc, dn;
        bit bok, sok;
        for (int i = 0; i < 5; i++) begin
            start_op(1'b1, ta[i], tb[i]);
            wait_done(0, cyc, bok, sok, dn);
            e = sb_q.pop_front();
            n_checks++;
            if (cyc !== e.lat || dn != 1) begin
                n_fail++;
                $display("FAIL div_latency[%0d]: done at cycle %0d (%0d pulses), expected cycle %0d once", i, cyc, dn, e.lat);
            end
            n_checks++;
            if (hi_out !== e.hi || lo_out !== e.lo) begin
                n_fail++;
                $display("FAIL div_result[%0d]: hi=%h lo=%h, expected hi=%h lo=%h", i, hi_out, lo_out, e.hi, e.lo);
            end
            n_checks++;
            if (!bok || !sok || div_zero !== e.dz) begin
                n_fail++;
                $display("FAIL div_busy_stable[%0d]: busy_ok=%0b stable_ok=%0b div_zero=%b, expected 1/1/%b", i, bok, sok, div_zero, e.dz);
            end
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        int cyc, dn;
        bit bok, sok;
        // 0x451 / 0x20 leaves HI = 0x11, LO = 0x22
        start_op(1'b1, 32'h0000_0451, 32'h0000_0020);
        wait_done(0, cyc, bok, sok, dn);
        e = sb_q.pop_front();
        n_checks++;
        if (hi_out !== e.hi || lo_out !== e.lo) begin
            n_fail++;
            $display("FAIL divz_setup: hi=%h lo=%h, expected hi=%h lo=%h", hi_out, lo_out, e.hi, e.lo);
        end
        start_op(1'b1, 32'h0000_0005, 32'h0000_0000);
        wait_done(0, cyc, bok, sok, dn);
        e = sb_q.pop_front();
        n_checks++;
        if (cyc !== e.lat || dn != 1) begin
            n_fail++;
            $display("FAIL divz_latency: done at cycle %0d (%0d pulses), expected cycle %0d once", cyc, dn, e.lat);
        end
        n_checks++;
        if (hi_out !== e.hi || lo_out !== e.lo || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL divz_result: hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b", hi_out, lo_out, div_zero, e.hi, e.lo, e.dz);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (div_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL divz_sticky: div_zero=%b, expected 1", div_zero);
        end
        start_op(1'b0, 32'h0000_0003, 32'h0000_0004);
        n_checks++;
        if (div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL divz_clear: div_zero=%b after accepted start, expected 0", div_zero);
        end
        wait_done(0, cyc, bok, sok, dn);
        e = sb_q.pop_front();
        n_checks++;
        if (hi_out !== e.hi || lo_out !== e.lo || cyc !== e.lat) begin
            n_fail++;
            $display("FAIL divz_next: hi=%h lo=%h cycle=%0d, expected hi=%h lo=%h cycle=%0d", hi_out, lo_out, cyc, e.hi, e.lo, e.lat);
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int cyc, dn;
        bit bok, sok;
        start_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
        wait_done(10, cyc, bok, sok, dn);
        e = sb_q.pop_front();
        n_checks++;
        if (cyc !== e.lat || dn != 1) begin
            n_fail++;
            $display("FAIL ignore_latency: done at cycle %0d (%0d pulses), expected cycle %0d once", cyc, dn, e.lat);
        end
        n_checks++;
        if (hi_out !== e.hi || lo_out !== e.lo || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=0", hi_out, lo_out, div_zero, e.hi, e.lo);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int cyc, dn;
        bit bok, sok;
        int extra_done;
        start_op(1'b1, 32'hFFFF_FC18, 32'h0000_0003);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        void'(sb_q.pop_back());
        model_hi = '0;
        model_lo = '0;
        n_checks++;
        if ({busy, done} !== 2'b00 || hi_out !== '0 || lo_out !== '0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b hi=%h lo=%h, expected 0/0/0/0", busy, done, hi_out, lo_out);
        end
        extra_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        n_checks++;
        if (extra_done != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d busy/done cycles after abort, expected 0", extra_done);
        end
        start_op(1'b1, 32'hFFFF_FC18, 32'h0000_0003);
        wait_done(0, cyc, bok, sok, dn);
        e = sb_q.pop_front();
        n_checks++;
        if (hi_out !== e.hi || lo_out !== e.lo || cyc !== e.lat) begin
            n_fail++;
            $display("FAIL abort_restart: hi=%h lo=%h cycle=%0d, expected hi=%h lo=%h cycle=%0d", hi_out, lo_out, cyc, e.hi, e.lo, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int cyc, dn;
        bit bok, sok;
        logic o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 12; i++) begin
            o = $urandom_range(1, 0) == 1;
            x = $urandom;
            y = (i % 5 == 4) ? 32'h0 : $urandom;
            if (i % 3 == 2) y = {{(W-8){y[7]}}, y[7:0]};
            start_op(o, x, y);
            wait_done(0, cyc, bok, sok, dn);
            e = sb_q.pop_front();
            n_checks++;
            if (hi_out !== e.hi || lo_out !== e.lo || div_zero !== e.dz || cyc !== e.lat || dn != 1) begin
                n_fail++;
                $display("FAIL b2b[%0d] op=%0b a=%h b=%h: hi=%h lo=%h dz=%b cycle=%0d, expected hi=%h lo=%h dz=%b cycle=%0d",
                         i, o, x, y, hi_out, lo_out, div_zero, cyc, e.hi, e.lo, e.dz, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
